// File: rtl/mult_div_pkg.sv
// Shared encodings for the 8x8 multiplier / 16by8 divider pair and their
// common 7-segment status decoder.
package mult_div_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;

  // 3-bit state codes, also consumed by the display decoder
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_CALC = 3'd2;
  localparam logic [2:0] ST_FIN  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [DIVIDEND_W-1:0] ERR_QUOTIENT = 16'hFFFF;
  localparam logic [3:0]            LAST_STEP    = 4'd15;

endpackage

// File: rtl/divider_controller.sv
// Start/done handshake FSM and 4-bit step counter for the restoring divider.
module divider_controller
  import mult_div_pkg::*;
(
  input  logic       clk,
  input  logic       reset_a,
  input  logic       start,
  input  logic       divisor_zero,
  output logic       load_en,
  output logic       step_en,
  output logic       err_set,
  output logic       done_flag,
  output logic [2:0] state_out
);

  logic [2:0] state_r;
  logic [2:0] state_nx_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_nx_s;
  logic       done_r;

  // Next-state and counter decode
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nx_s = ST_LOAD;
        else       state_nx_s = ST_IDLE;
      end
      ST_LOAD: begin
        cnt_nx_s = LAST_STEP;
        if (divisor_zero) state_nx_s = ST_ERR;
        else              state_nx_s = ST_CALC;
      end
      ST_CALC: begin
        if (cnt_r == 4'd0) state_nx_s = ST_FIN;
        else               cnt_nx_s   = cnt_r - 4'd1;
      end
      ST_FIN, ST_ERR: begin
        // no restart until start has been seen low
        if (!start) state_nx_s = ST_IDLE;
        else        state_nx_s = state_r;
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = 4'd0;
      end
    endcase
  end

  // State, counter and registered done flag
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      done_r  <= (state_nx_s == ST_FIN) || (state_nx_s == ST_ERR);
    end
  end

  assign state_out = state_r;
  assign done_flag = done_r;
  assign load_en   = (state_r == ST_LOAD);
  assign step_en   = (state_r == ST_CALC);
  assign err_set   = load_en & divisor_zero;

endmodule

// File: rtl/divider_16by8.sv
// Sequential restoring divider, 16-bit dividend / 8-bit divisor, one
// quotient bit per clock.
module divider_16by8
  import mult_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_a,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dataa,
  input  logic [DIVISOR_W-1:0]  datab,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  done_flag,
  output logic                  div_by_zero,
  output logic [2:0]            state_out
);

  logic                  load_en;
  logic                  step_en;
  logic                  err_set;
  logic [DIVIDEND_W-1:0] q_r;
  logic [DIVISOR_W:0]    r_r;
  logic [DIVISOR_W-1:0]  divisor_r;
  logic [DIVISOR_W:0]    trial_s;
  logic [DIVISOR_W:0]    diff_s;
  logic                  fits_s;

  divider_controller u_ctrl (
    .clk          (clk),
    .reset_a      (reset_a),
    .start        (start),
    .divisor_zero (datab == 8'd0),
    .load_en      (load_en),
    .step_en      (step_en),
    .err_set      (err_set),
    .done_flag    (done_flag),
    .state_out    (state_out)
  );

  // Shift the next dividend bit into the partial remainder and trial-subtract
  always_comb begin
    trial_s = {r_r[DIVISOR_W-1:0], q_r[DIVIDEND_W-1]};
    fits_s  = (trial_s >= {1'b0, divisor_r});
    diff_s  = trial_s - {1'b0, divisor_r};
  end

  // Quotient shift register, partial remainder and captured divisor
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      q_r       <= 16'd0;
      r_r       <= 9'd0;
      divisor_r <= 8'd0;
    end else if (load_en) begin
      q_r       <= err_set ? ERR_QUOTIENT : dataa;
      r_r       <= 9'd0;
      divisor_r <= datab;
    end else if (step_en) begin
      q_r <= {q_r[DIVIDEND_W-2:0], fits_s};
      r_r <= fits_s ? diff_s : trial_s;
    end else begin
      q_r       <= q_r;
      r_r       <= r_r;
      divisor_r <= divisor_r;
    end
  end

  // r_r[8] is always clear once a step has completed
  assign quotient    = q_r;
  assign remainder   = r_r[DIVISOR_W-1:0];
  assign div_by_zero = (state_out == ST_ERR);

endmodule

// File: tb/tb_divider_16by8.sv
// Randomized self-checking bench for divider_16by8 against an arithmetic model.
module tb_divider_16by8;

  logic        clk;
  logic        reset_a;
  logic        start;
  logic [15:0] dataa;
  logic [7:0]  datab;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        done_flag;
  logic        div_by_zero;
  logic [2:0]  state_out;

  int checks;
  int failures;

  divider_16by8 dut (
    .clk         (clk),
    .reset_a     (reset_a),
    .start       (start),
    .dataa       (dataa),
    .datab       (datab),
    .quotient    (quotient),
    .remainder   (remainder),
    .done_flag   (done_flag),
    .div_by_zero (div_by_zero),
    .state_out   (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_q"},    32'(quotient),    32'd0);
    check_eq({tag, "_r"},    32'(remainder),   32'd0);
    check_eq({tag, "_done"}, 32'(done_flag),   32'd0);
    check_eq({tag, "_dbz"},  32'(div_by_zero), 32'd0);
    check_eq({tag, "_st"},   32'(state_out),   32'd0);
  endtask

  // One operation; disturb scrambles operands/start after capture, hold keeps start high
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        input bit disturb, input bit hold);
    logic [15:0] exp_q;
    logic [7:0]  exp_r;
    int          exp_lat;
    int          cycles;
    if (b == 8'd0) begin
      exp_q = 16'hFFFF; exp_r = 8'd0; exp_lat = 2;
    end else begin
      exp_q = a / 16'(b); exp_r = 8'(a % 16'(b)); exp_lat = 18;
    end
    @(negedge clk);
    dataa = a; datab = b; start = 1'b1;
    cycles = 0;
    while (cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (!hold) begin
        if (disturb && cycles >= 4 && cycles <= 8) begin
          dataa = 16'($urandom);
          datab = 8'($urandom);
          start = 1'($urandom_range(0, 1));
        end else begin
          start = 1'b0;
        end
      end
      if (done_flag) break;
    end
    check_eq("latency",   32'(cycles),      32'(exp_lat));
    check_eq("quotient",  32'(quotient),    32'(exp_q));
    check_eq("remainder", 32'(remainder),   32'(exp_r));
    check_eq("done",      32'(done_flag),   32'd1);
    check_eq("dbz",       32'(div_by_zero), 32'(b == 8'd0));
    check_eq("state_fin", 32'(state_out),   (b == 8'd0) ? 32'd4 : 32'd3);
    if (hold) begin
      repeat (12) @(negedge clk);
      check_eq("hold_state", 32'(state_out), (b == 8'd0) ? 32'd4 : 32'd3);
      check_eq("hold_q",     32'(quotient),  32'(exp_q));
      check_eq("hold_r",     32'(remainder), 32'(exp_r));
      start = 1'b0;
    end
    @(negedge clk);
    check_eq("idle_state", 32'(state_out),   32'd0);
    check_eq("idle_done",  32'(done_flag),   32'd0);
    check_eq("idle_dbz",   32'(div_by_zero), 32'd0);
    check_eq("idle_q",     32'(quotient),    32'(exp_q));
    check_eq("idle_r",     32'(remainder),   32'(exp_r));
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    checks   = 0;
    failures = 0;
    reset_a  = 1'b0;
    start    = 1'b0;
    dataa    = 16'd0;
    datab    = 8'd0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_a = 1'b1;

    run_op(16'd1000,  8'd7,   1'b0, 1'b0);
    run_op(16'hFFFF,  8'd1,   1'b0, 1'b0);
    run_op(16'hFFFF,  8'hFF,  1'b0, 1'b0);
    run_op(16'd100,   8'd200, 1'b0, 1'b0);
    run_op(16'd5,     8'd0,   1'b0, 1'b0);
    run_op(16'd1000,  8'd7,   1'b0, 1'b1);
    run_op(16'd50000, 8'd250, 1'b0, 1'b0);
    run_op(16'd12345, 8'd3,   1'b1, 1'b0);

    // Abort mid-CALC with an asynchronous reset pulse
    @(negedge clk);
    dataa = 16'hFFFF; datab = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("pre_abort_st", 32'(state_out), 32'd2);
    #2 reset_a = 1'b0;
    #1 check_all_zero("abort");
    @(negedge clk);
    reset_a = 1'b1;
    run_op(16'd255, 8'd16, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divider_16by8.md
# divider_16by8

Sequential restoring divider: divides a 16-bit unsigned dividend by an 8-bit unsigned divisor and produces a 16-bit quotient and an 8-bit remainder, one quotient bit per clock. It is the inverse-operation companion to the 8x8 sequential multiplier. It uses the same start/done handshake and the same 3-bit state code for the 7-segment status display, so both blocks share one front-end and one display decoder.

## Interface
- No parameters. All widths are fixed.
- `clk`  in  1  rising-edge clock.
- `reset_a`  in  1  asynchronous, active-low reset.
- `start`  in  1  level request. Sampled only in IDLE; must return low before the next operation is accepted.
- `dataa`  in  16  dividend. Captured in LOAD.
- `datab`  in  8  divisor. Captured in LOAD.
- `quotient`  out  16  result quotient. Registered.
- `remainder`  out  8  result remainder. Registered.
- `done_flag`  out  1  high in FIN and ERR.
- `div_by_zero`  out  1  high in ERR.
- `state_out`  out  3  current state code, for the display decoder.

## Operation
- State codes: IDLE=0, LOAD=1, CALC=2, FIN=3, ERR=4. Codes 5–7 are illegal and go to IDLE on the next clock.
- IDLE → LOAD when `start`=1; otherwise stay in IDLE.
- LOAD:
  - Capture `dataa` into the quotient shift register and `datab` into the divisor register.
  - Clear the 9-bit partial remainder `r`.
  - Load the bit counter with 15.
  - If `datab`=0, go to ERR; otherwise go to CALC.
- CALC step, performed each cycle:
  - t = {r[7:0], q[15]}.
  - If t ≥ {1'b0, divisor}: r ← t − divisor and the new quotient LSB = 1. Otherwise r ← t and the new LSB = 0.
  - q ← {q[14:0], LSB}.
  - Counter decrements. When the step runs with counter=0, go to FIN.
- Width rules: `r` is 9 bits so the compare never overflows. `remainder` = r[7:0]; r[8] is always 0 after a step.
- FIN: `done_flag`=1. Return to IDLE only when `start`=0. If `start` stays high, stay in FIN with no restart.
- ERR:
  - `quotient`=16'hFFFF, `remainder`=8'h00, `done_flag`=1, `div_by_zero`=1.
  - Leaves to IDLE under the same rule as FIN.
- `quotient` and `remainder` hold their last values through IDLE until the next LOAD. In LOAD they change to their working values (q = dividend, r = 0).
- `start` is ignored in LOAD and CALC.
- `dataa` and `datab` changes after LOAD do not affect the operation in progress.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE.
  - `quotient`, `remainder`, `done_flag`, `div_by_zero` and `state_out` all become 0.
  - Counter and `r` clear.
- Reset asserted mid-CALC aborts the operation immediately; no partial result is kept.
- Latency, where edge E0 is the first edge that sees `start`=1 in IDLE:
  - E0: enter LOAD.
  - E1: capture operands; enter CALC.
  - E2 through E17: the 16 CALC steps.
  - After E17: FIN, `done_flag`=1, results valid.
  - Total: 18 clocks from start to done.
- Divide by zero: ERR after E1; `done_flag` high 2 clocks after start.
- `done_flag` and `div_by_zero` are Moore outputs decoded from the state register, with no combinational path from inputs.
- Back-to-back throughput: one operation per 19 clocks minimum, since `start` must be seen low for one cycle in FIN.

## Structure
- Shared package `mult_div_pkg` holds:
  - the state encoding constants (IDLE..ERR, 3 bits), shared with the multiplier controller and display decoder;
  - the operand widths (16/8) and the error quotient constant 16'hFFFF.
- One sub-module, `divider_controller`:
  - holds the FSM and the 4-bit step counter;
  - outputs `load_en`, `step_en`, `err_set`, `done_flag` and `state_out`.
- The datapath (q, r and divisor registers, the compare/subtract) stays in the top module.
- Reuse the existing `segment_7` at the system level; it is not instantiated inside this block.

## Test plan
- 1000 / 7 (`dataa`=16'd1000, `datab`=8'd7, 1-cycle `start`) → after 18 clocks: `quotient`=142, `remainder`=6, `done_flag`=1, `div_by_zero`=0, `state_out`=3.
- Extremes:
  - 16'hFFFF / 1 → `quotient`=16'hFFFF, `remainder`=0.
  - 16'hFFFF / 8'hFF → `quotient`=257, `remainder`=0.
  - 100 / 200 → `quotient`=0, `remainder`=100.
- 5 / 0 → ERR 2 clocks after start: `quotient`=16'hFFFF, `remainder`=0, `div_by_zero`=1, `done_flag`=1, `state_out`=4. Lowering `start` returns to IDLE with `div_by_zero`=0.
- `start` held high through completion → stays in FIN, results stable for 10+ cycles. Lowering `start` → IDLE next clock. Raising it again runs 50000/250 = 200 r 0.
- Operand change and `start` pulses during CALC → ignored; the result matches the operands captured in LOAD.
- `reset_a` pulsed low at the 8th CALC cycle → outputs 0 asynchronously, `state_out`=0. A following 255/16 gives 15 r 15.
